mash_ramp_ctrl: RTL and testbench

Configuration sequencer for the MASH 1-1-1 fractional-N modulator core. It accepts new frequency words (integer + fractional) over a valid/ready handshake and ramps the modulator input from its current value to the target in programmable steps at a programmable interval, so the synthesizer never sees a large instantaneous frequency jump. It can optionally issue a one-cycle accumulator clear before the ramp starts, and it reports busy and done status to the register interface. It sits between the control register block and the modulator's `in_i`/`in_f` inputs, in the modulator clock domain.

---
 rtl/mash_ramp_ctrl_if.sv | 30 +++
 rtl/mash_ramp_ctrl.sv | 93 +++++++++
 tb/tb_mash_ramp_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mash_ramp_ctrl_if.sv
// Configuration and modulator-word bundle between the register block (master) and the ramp sequencer (slave).
interface mash_ramp_ctrl_if #(
    parameter int INT_W  = 4,
    parameter int FRAC_W = 16,
    parameter int INTV_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic [FRAC_W-1:0] cfg_step;
    logic [INTV_W-1:0] cfg_intv;
    logic              cfg_clr;
    logic              abort;
    logic [INT_W-1:0]  mod_int;
    logic [FRAC_W-1:0] mod_frac;
    logic              mod_clr;
    logic              busy;
    logic              done;

    modport master (
        output cfg_valid, cfg_int, cfg_frac, cfg_step, cfg_intv, cfg_clr, abort,
        input  cfg_ready, mod_int, mod_frac, mod_clr, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_frac, cfg_step, cfg_intv, cfg_clr, abort,
        output cfg_ready, mod_int, mod_frac, mod_clr, busy, done
    );
endinterface

// File: rtl/mash_ramp_ctrl.sv
// Ramps the MASH modulator input word toward a new target in clamped steps, one step per intv+1 cycles.
// First update one edge after accept (two with clear); cfg_ready is high only in IDLE, no queuing.
module mash_ramp_ctrl #(
    parameter int INT_W  = 4,
    parameter int FRAC_W = 16,
    parameter int INTV_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mash_ramp_ctrl_if.slave bus
);
    localparam int W = INT_W + FRAC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [W-1:0]      cur;
    logic [W-1:0]      tgt;
    logic [FRAC_W-1:0] step;
    logic [INTV_W-1:0] intv;
    logic [INTV_W-1:0] cnt;

    logic              up;
    logic [W-1:0]      diff;
    logic [W-1:0]      step_ext;

    always_comb begin
        up       = tgt > cur;
        diff     = up ? (tgt - cur) : (cur - tgt);
        step_ext = {{INT_W{1'b0}}, step};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cur   <= '0;
            tgt   <= '0;
            step  <= '0;
            intv  <= '0;
            cnt   <= '0;
        end else if (state != S_IDLE && bus.abort) begin
            // cur is deliberately left where the ramp stopped
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cfg_valid) begin
                        tgt   <= {bus.cfg_int, bus.cfg_frac};
                        step  <= bus.cfg_step;
                        intv  <= bus.cfg_intv;
                        state <= bus.cfg_clr ? S_CLR : S_STEP;
                    end
                end
                S_CLR: state <= S_STEP;
                S_STEP: begin
                    if (diff == '0) begin
                        state <= S_DONE;
                    end else if (step == '0 || diff <= step_ext) begin
                        cur   <= tgt;
                        state <= S_DONE;
                    end else begin
                        cur <= up ? (cur + step_ext) : (cur - step_ext);
                        if (intv == '0) begin
                            state <= S_STEP;
                        end else begin
                            cnt   <= intv;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - INTV_W'(1);
                    if (cnt == INTV_W'(1)) state <= S_STEP;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mod_int   = cur[W-1:FRAC_W];
    assign bus.mod_frac  = cur[FRAC_W-1:0];
    assign bus.mod_clr   = (state == S_CLR);
    assign bus.done      = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.cfg_ready = (state == S_IDLE);
endmodule

// File: tb/tb_mash_ramp_ctrl.sv
// Bench for mash_ramp_ctrl: directed scenarios plus random ramps against a trajectory model.
module tb_mash_ramp_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [19:0] model_cur;

    mash_ramp_ctrl_if #(.INT_W(4), .FRAC_W(16), .INTV_W(8)) bus ();

    mash_ramp_ctrl #(.INT_W(4), .FRAC_W(16), .INTV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model: list every update (edge offset, value) from plain walk-toward-target arithmetic,
    // then check each cycle's outputs against that timeline.
    task automatic run_cfg(input logic [19:0] t, input logic [15:0] st, input logic [7:0] iv,
                           input logic c, input int abort_at, input bit noise, input string nm,
                           output int n_done, output int n_clr,
                           output logic [19:0] lo, output logic [19:0] hi);
        logic [19:0] start, v, d, ev, obs;
        int          upd_e[$];
        logic [19:0] upd_v[$];
        int          e, done_e, last, lim;
        bit          ab, ebusy, edone, eclr;
        start  = model_cur;
        v      = start;
        e      = c ? 2 : 1;
        done_e = e;
        while (v != t) begin
            d = (t > v) ? (t - v) : (v - t);
            if (st == 16'h0 || d <= {4'h0, st}) v = t;
            else if (t > v) v = v + {4'h0, st};
            else v = v - {4'h0, st};
            upd_e.push_back(e);
            upd_v.push_back(v);
            done_e = e;
            e = e + int'(iv) + 1;
        end
        last   = (abort_at >= 0) ? abort_at + 2 : done_e + 1;
        n_done = 0;
        n_clr  = 0;
        lo     = start;
        hi     = start;
        ev     = start;

        @(posedge clk); #1;
        bus.cfg_int   = t[19:16];
        bus.cfg_frac  = t[15:0];
        bus.cfg_step  = st;
        bus.cfg_intv  = iv;
        bus.cfg_clr   = c;
        bus.cfg_valid = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j <= last; j++) begin
            ab        = (abort_at >= 0) && (j > abort_at);
            bus.abort = (j == abort_at);
            if (noise && !ab && j <= done_e) begin
                bus.cfg_valid = 1'($urandom_range(0, 1));
                bus.cfg_int   = 4'($urandom);
                bus.cfg_frac  = 16'($urandom);
                bus.cfg_step  = 16'($urandom);
                bus.cfg_clr   = 1'($urandom);
            end else begin
                bus.cfg_valid = 1'b0;
            end
            lim = ab ? abort_at : j;
            ev  = start;
            foreach (upd_e[i]) if (upd_e[i] <= lim) ev = upd_v[i];
            ebusy = !ab && (j <= done_e);
            edone = !ab && (j == done_e);
            eclr  = !ab && c && (j == 0);
            @(negedge clk);
            obs = {bus.mod_int, bus.mod_frac};
            if (obs !== ev) begin
                bad++;
                $display("FAIL %s word j=%0d got=%h want=%h", nm, j, obs, ev);
            end
            total++;
            if (bus.done !== edone) begin
                bad++;
                $display("FAIL %s done j=%0d got=%b want=%b", nm, j, bus.done, edone);
            end
            total++;
            if (bus.mod_clr !== eclr) begin
                bad++;
                $display("FAIL %s mod_clr j=%0d got=%b want=%b", nm, j, bus.mod_clr, eclr);
            end
            total++;
            if (bus.busy !== ebusy || bus.cfg_ready !== !ebusy) begin
                bad++;
                $display("FAIL %s busy/ready j=%0d got=%b/%b want=%b/%b", nm, j,
                         bus.busy, bus.cfg_ready, ebusy, !ebusy);
            end
            total++;
            if (bus.done === 1'b1) n_done++;
            if (bus.mod_clr === 1'b1) n_clr++;
            if (obs < lo) lo = obs;
            if (obs > hi) hi = obs;
            @(posedge clk); #1;
        end
        bus.abort     = 1'b0;
        bus.cfg_valid = 1'b0;
        model_cur     = ev;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst_n = 1'b0;
        #3;
        obs = {bus.mod_int, bus.mod_frac};
        if (obs !== 20'h0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 ||
            bus.done !== 1'b0 || bus.mod_clr !== 1'b0) begin
            bad++;
            $display("FAIL reset_init got word=%h busy=%b ready=%b done=%b clr=%b want 0/0/1/0/0",
                     obs, bus.busy, bus.cfg_ready, bus.done, bus.mod_clr);
        end
        total++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.cfg_int   = 4'h0;
        bus.cfg_frac  = 16'h8000;
        bus.cfg_step  = 16'h0100;
        bus.cfg_intv  = 8'd3;
        bus.cfg_clr   = 1'b0;
        bus.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        obs = {bus.mod_int, bus.mod_frac};
        if (obs !== 20'h00200 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_midramp_pre got word=%h busy=%b want 00200/1", obs, bus.busy);
        end
        total++;
        rst_n = 1'b0;
        #2;
        obs = {bus.mod_int, bus.mod_frac};
        if (obs !== 20'h0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got word=%h busy=%b ready=%b done=%b want 0/0/1/0",
                     obs, bus.busy, bus.cfg_ready, bus.done);
        end
        total++;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_cur = 20'h0;
    endtask

    task automatic test_jump();
        int nd, nc;
        logic [19:0] lo, hi;
        run_cfg(20'h2_8000, 16'h0, 8'd0, 1'b0, -1, 1'b0, "jump", nd, nc, lo, hi);
        if (nd !== 1) begin
            bad++;
            $display("FAIL jump_done_count got=%0d want=1", nd);
        end
        total++;
    endtask

    task automatic test_ramp_up();
        int nd, nc;
        logic [19:0] lo, hi;
        run_cfg(20'h0, 16'h0, 8'd0, 1'b0, -1, 1'b0, "to_zero", nd, nc, lo, hi);
        run_cfg(20'h0_0300, 16'h0100, 8'd2, 1'b0, -1, 1'b1, "ramp_up", nd, nc, lo, hi);
        if (nd !== 1 || hi !== 20'h00300) begin
            bad++;
            $display("FAIL ramp_up_summary got done=%0d max=%h want 1/00300", nd, hi);
        end
        total++;
    endtask

    task automatic test_ramp_down();
        int nd, nc;
        logic [19:0] lo, hi;
        run_cfg(20'h1_0000, 16'h0, 8'd0, 1'b0, -1, 1'b0, "to_10000", nd, nc, lo, hi);
        run_cfg(20'h0_FF50, 16'h0040, 8'd0, 1'b0, -1, 1'b0, "ramp_down", nd, nc, lo, hi);
        if (lo !== 20'h0FF50 || nd !== 1) begin
            bad++;
            $display("FAIL ramp_down_clamp got min=%h done=%0d want 0ff50/1", lo, nd);
        end
        total++;
    endtask

    task automatic test_clear_at_target();
        int nd, nc;
        logic [19:0] lo, hi, start;
        start = model_cur;
        run_cfg(start, 16'h0010, 8'd1, 1'b1, -1, 1'b0, "clr_at_tgt", nd, nc, lo, hi);
        if (nc !== 1 || nd !== 1 || lo !== start || hi !== start) begin
            bad++;
            $display("FAIL clr_at_tgt_summary got clr=%0d done=%0d min=%h max=%h want 1/1/%h/%h",
                     nc, nd, lo, hi, start, start);
        end
        total++;
    endtask

    task automatic test_abort();
        int nd, nc;
        logic [19:0] lo, hi, obs;
        run_cfg(20'h0, 16'h0, 8'd0, 1'b0, -1, 1'b0, "to_zero2", nd, nc, lo, hi);
        run_cfg(20'h0_0300, 16'h0100, 8'd2, 1'b0, 5, 1'b0, "abort", nd, nc, lo, hi);
        obs = {bus.mod_int, bus.mod_frac};
        if (nd !== 0 || obs !== 20'h00200) begin
            bad++;
            $display("FAIL abort_hold got done=%0d word=%h want 0/00200", nd, obs);
        end
        total++;
        run_cfg(20'h0_0300, 16'h0100, 8'd2, 1'b0, -1, 1'b0, "after_abort", nd, nc, lo, hi);
        if (lo !== 20'h00200 || nd !== 1) begin
            bad++;
            $display("FAIL after_abort_start got min=%h done=%0d want 00200/1", lo, nd);
        end
        total++;
    endtask

    task automatic test_random();
        int nd, nc, sv, ab;
        logic [19:0] lo, hi, t, d, tmp;
        logic [15:0] st;
        for (int n = 0; n < 25; n++) begin
            t  = ($urandom_range(0, 5) == 0) ? model_cur : 20'($urandom);
            d  = (t > model_cur) ? (t - model_cur) : (model_cur - t);
            tmp = d >> 3;
            if (tmp > 20'h0FFFF) tmp = 20'h0FFFF;
            sv = int'(tmp) + int'($urandom_range(1, 255));
            if (sv > 65535) sv = 65535;
            st = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'(sv);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_cfg(t, st, 8'($urandom_range(0, 3)), 1'($urandom), ab, 1'($urandom),
                    "random", nd, nc, lo, hi);
            if (ab < 0 && nd !== 1) begin
                bad++;
                $display("FAIL random_done_count n=%0d got=%0d want=1", n, nd);
            end
            total++;
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        model_cur     = 20'h0;
        rst_n         = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_int   = '0;
        bus.cfg_frac  = '0;
        bus.cfg_step  = '0;
        bus.cfg_intv  = '0;
        bus.cfg_clr   = 1'b0;
        bus.abort     = 1'b0;
        test_reset();
        test_jump();
        test_ramp_up();
        test_ramp_down();
        test_clear_at_target();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
